// File: rtl/setting_register_pkg.sv
// Settings-bus geometry and the system register address map shared by every
// block that decodes a setting_register instance.
package setting_register_pkg;

    localparam int SR_AWIDTH = 7;
    localparam int SR_DWIDTH = 32;

    // DDC channel 0
    localparam logic [SR_AWIDTH-1:0] SR_DDC0_FREQ      = 7'd16;
    localparam logic [SR_AWIDTH-1:0] SR_DDC0_PHASE_RST = 7'd17;
    localparam logic [SR_AWIDTH-1:0] SR_DDC0_SCALE_IQ  = 7'd18;
    localparam logic [SR_AWIDTH-1:0] SR_DDC0_DECIM     = 7'd19;

    // DDC channel 1
    localparam logic [SR_AWIDTH-1:0] SR_DDC1_FREQ      = 7'd24;
    localparam logic [SR_AWIDTH-1:0] SR_DDC1_PHASE_RST = 7'd25;
    localparam logic [SR_AWIDTH-1:0] SR_DDC1_SCALE_IQ  = 7'd26;
    localparam logic [SR_AWIDTH-1:0] SR_DDC1_DECIM     = 7'd27;

    // Global control
    localparam logic [SR_AWIDTH-1:0] SR_CORE_CTRL      = 7'd0;
    localparam logic [SR_AWIDTH-1:0] SR_LAST           = 7'd127;

endpackage

// File: rtl/setting_register.sv
// Single settings-bus register: captures the bus word on a strobe addressed to
// MY_ADDR and pulses changed for one cycle afterwards.
module setting_register
    import setting_register_pkg::*;
#(
    parameter int                 MY_ADDR = 0,
    parameter int                 AWIDTH  = SR_AWIDTH,
    parameter int                 DWIDTH  = SR_DWIDTH,
    parameter logic [DWIDTH-1:0]  INIT    = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              strobe,
    input  logic [AWIDTH-1:0] addr,
    input  logic [DWIDTH-1:0] in,
    output logic [DWIDTH-1:0] out,
    output logic              changed
);

    localparam logic [AWIDTH-1:0] MATCH_ADDR = AWIDTH'(MY_ADDR);

    logic hit;
    assign hit = strobe && (addr == MATCH_ADDR);

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (reset) begin
            out     <= INIT;
            changed <= 1'b0;
        end else begin
            if (hit)
                out <= in;
            changed <= hit;
        end
    end

endmodule

// File: tb/tb_setting_register.sv
// Self-checking bench for setting_register: directed test-plan sequence with
// literal expectations, then randomized bus traffic against a reference model.
module tb_setting_register;

    localparam int AW = 7;
    localparam int DW = 32;
    localparam int N  = 2;
    localparam logic [AW-1:0] ADDRS [N] = '{7'd5, 7'd127};

    logic          clk = 1'b0;
    logic          reset;
    logic          strobe;
    logic [AW-1:0] addr;
    logic [DW-1:0] in;
    logic [DW-1:0] out_a, out_b;
    logic          changed_a, changed_b;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    setting_register #(.MY_ADDR(5), .AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk(clk), .reset(reset), .strobe(strobe), .addr(addr), .in(in),
        .out(out_a), .changed(changed_a)
    );

    setting_register #(.MY_ADDR(127), .AWIDTH(AW), .DWIDTH(DW)) dut_hi (
        .clk(clk), .reset(reset), .strobe(strobe), .addr(addr), .in(in),
        .out(out_b), .changed(changed_b)
    );

    task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each register holds the last word written to its
    // address since the most recent reset; changed reports whether the
    // previous edge carried an accepted write.
    logic [DW-1:0] model_val [N];
    bit            model_pulse [N];
    bit            model_valid = 0;

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            bit wrote;
            wrote = !reset && strobe && (addr == ADDRS[i]);
            if (reset)      model_val[i] = '0;
            else if (wrote) model_val[i] = in;
            model_pulse[i] = wrote;
        end
        if (reset) model_valid = 1;
    end

    always @(negedge clk) begin
        if (model_valid) begin
            check("model out a",     out_a,           model_val[0]);
            check("model changed a", 32'(changed_a),  32'(model_pulse[0]));
            check("model out b",     out_b,           model_val[1]);
            check("model changed b", 32'(changed_b),  32'(model_pulse[1]));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic s, input logic [AW-1:0] a, input logic [DW-1:0] d);
        reset  = r;
        strobe = s;
        addr   = a;
        in     = d;
        tick();
    endtask

    initial begin
        reset = 1'b1; strobe = 1'b0; addr = '0; in = '0;
        #1;

        // Reset has priority over a matching strobe
        drive(1, 1, 7'd5, 32'hDEADBEEF);
        check("reset out",        out_a,         32'h0);
        check("reset changed",    32'(changed_a), 32'h0);
        drive(1, 1, 7'd5, 32'hDEADBEEF);
        check("reset out 2",      out_a,         32'h0);
        check("reset changed 2",  32'(changed_a), 32'h0);

        // Matching write, then hold
        drive(0, 1, 7'd5, 32'h12345678);
        check("write out",        out_a,          32'h12345678);
        check("write changed",    32'(changed_a), 32'h1);
        drive(0, 0, 7'd5, 32'h12345678);
        check("hold out",         out_a,          32'h12345678);
        check("hold changed",     32'(changed_a), 32'h0);

        // Non-matching strobe and idle bus activity
        drive(0, 1, 7'd6, 32'hFFFFFFFF);
        check("miss out",         out_a,          32'h12345678);
        check("miss changed",     32'(changed_a), 32'h0);
        drive(0, 0, 7'd5, 32'hA5A5A5A5);
        check("idle out",         out_a,          32'h12345678);
        check("idle changed",     32'(changed_a), 32'h0);

        // Back-to-back writes
        drive(0, 1, 7'd5, 32'h1);
        check("b2b out 1",        out_a,          32'h1);
        check("b2b changed 1",    32'(changed_a), 32'h1);
        drive(0, 1, 7'd5, 32'h2);
        check("b2b out 2",        out_a,          32'h2);
        check("b2b changed 2",    32'(changed_a), 32'h1);
        drive(0, 0, 7'd0, 32'h0);
        check("b2b changed end",  32'(changed_a), 32'h0);

        // Same value still pulses; extreme data values
        drive(0, 1, 7'd5, 32'h2);
        check("same out",         out_a,          32'h2);
        check("same changed",     32'(changed_a), 32'h1);
        drive(0, 1, 7'd5, 32'h0);
        check("zero out",         out_a,          32'h0);
        drive(0, 1, 7'd5, 32'hFFFFFFFF);
        check("ones out",         out_a,          32'hFFFFFFFF);

        // Top address instance decodes only 7'h7F
        drive(0, 1, 7'h7F, 32'hCAFEF00D);
        check("hi out",           out_b,          32'hCAFEF00D);
        check("hi changed",       32'(changed_b), 32'h1);
        check("lo ignores hi",    out_a,          32'hFFFFFFFF);
        drive(0, 1, 7'h3F, 32'h11111111);
        check("hi ignores 3f",    out_b,          32'hCAFEF00D);
        check("hi no pulse",      32'(changed_b), 32'h0);

        // Reset mid-operation with a concurrent matching strobe
        drive(0, 1, 7'd5, 32'h2);
        check("pre-reset out",    out_a,          32'h2);
        drive(1, 1, 7'd5, 32'h9);
        check("mid reset out",    out_a,          32'h0);
        check("mid reset chg",    32'(changed_a), 32'h0);
        check("mid reset hi",     out_b,          32'h0);
        drive(0, 1, 7'd5, 32'h9);
        check("post reset out",   out_a,          32'h9);
        check("post reset chg",   32'(changed_a), 32'h1);

        // Randomized traffic, biased toward the two decoded addresses
        for (int n = 0; n < 3000; n++) begin
            logic [AW-1:0] a;
            case ($urandom_range(0, 3))
                0:       a = 7'd5;
                1:       a = 7'd127;
                default: a = AW'($urandom_range(0, 127));
            endcase
            drive(($urandom_range(0, 63) == 0), ($urandom_range(0, 2) != 0), a, $urandom);
        end

        drive(0, 0, 7'd0, 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/setting_register.md
Name: setting_register

Overview:
- Single addressable configuration register on the shared serial-settings bus (7-bit address, 32-bit data, one-cycle strobe).
- Captures the bus data when the strobe coincides with its own address. Holds the value until the next matching write or a reset.
- Provides a one-cycle "changed" pulse. Instantiated by DSP blocks for run-time parameters, e.g. the phase accumulator frequency word, which it feeds to the NCO.

Parameters:
- MY_ADDR, 0, bus address this register responds to (0..2^AWIDTH-1).
- AWIDTH, 7, settings-bus address width.
- DWIDTH, 32, data and register width.
- INIT, 0, value loaded into out on reset (DWIDTH bits).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- strobe  input  1  settings-bus write strobe; one-cycle qualifier for addr/in.
- addr  input  AWIDTH  settings-bus address.
- in  input  DWIDTH  settings-bus write data.
- out  output  DWIDTH  current register value (registered).
- changed  output  1  one-cycle pulse, asserted the cycle after a matching write is captured.

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Reset, evaluated on the rising clk edge with reset=1:
  - out <= INIT (default 0).
  - changed <= 0.
  - Reset has priority over any concurrent strobe.
- Write: on an edge where reset=0, strobe=1 and addr==MY_ADDR:
  - out <= in.
  - changed <= 1.
  - Latency is one clock; out shows the new value the cycle after the strobe.
- All other edges:
  - out holds its value.
  - changed <= 0.
- changed is high for exactly one cycle per accepted write. Back-to-back matching strobes keep changed high on each following cycle, and out takes each new value in turn.
- Writing the same value as currently held still pulses changed.
- strobe=1 with a non-matching addr: no effect on out or changed.
- addr or in changing while strobe=0: no effect.
- Full DWIDTH value is captured with no truncation or sign handling. Address comparison uses all AWIDTH bits.
- No read path, handshake or backpressure. Writes are fire-and-forget, and every matching strobe is accepted.
- out is driven directly from a flop (glitch-free), so consumers may use it combinationally.
- Multiple instances may share one bus. Each decodes only its own MY_ADDR. Duplicate addresses are legal and update all matching instances together.

Decomposition:
- Shared package holds:
  - settings-bus constants: SR_AWIDTH=7, SR_DWIDTH=32.
  - the system address map (localparams for each register address, e.g. the frequency and phase-reset addresses of each DDC channel).
- No sub-module. The block is a flat register with an address comparator.
- A bank wrapper that generates N instances from an address list may be built separately. It is not part of this block.

Test Plan:
- Reset: hold reset=1 for 2 cycles with strobe=1, addr=MY_ADDR, in=32'hDEADBEEF -> out==INIT (0), changed==0 throughout.
- Matching write: MY_ADDR=5, single-cycle strobe with addr=5, in=32'h12345678 -> next cycle out==32'h12345678 and changed==1; one cycle later changed==0 and out holds.
- Non-matching write: strobe with addr=6, in=32'hFFFFFFFF -> out unchanged (32'h12345678), changed stays 0. Also drive addr=5, in=32'hA5A5A5A5 with strobe=0 -> no effect.
- Back-to-back: strobe two consecutive cycles at addr=5 with in=32'h1, then 32'h2 -> out==1 then 2 on successive cycles, changed high for both cycles then low.
- Same-value and boundary: rewrite 32'h2 -> changed pulses. Write 32'h0 and 32'hFFFFFFFF -> captured exactly. Instance with MY_ADDR=127 responds only to addr=7'h7F.
- Reset mid-operation: after out==32'h2, assert reset together with a matching strobe (in=32'h9) -> out==INIT, changed==0. A matching write in the next cycle after reset deasserts is accepted normally.
